// File: rtl/icache_refill_if.sv
// Refill engine bus: fetch-side miss inputs, L1 write port and memory read port.
// master = refill engine, slave = surrounding fetch/L1/memory.
interface icache_refill_if #(
  parameter int ADDR_SIZE = 14,
  parameter int WORD_SIZE = 32
);
  logic                 fetch_en;
  logic [ADDR_SIZE-1:0] pc_addr;
  logic                 cache_hit;
  logic                 stall;
  logic                 cache_we;
  logic [ADDR_SIZE-1:0] cache_addr;
  logic [WORD_SIZE-1:0] cache_data;
  logic                 mem_rd;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_valid;
  logic                 busy;

  modport master (
    input  fetch_en, pc_addr, cache_hit,
    input  mem_rdata, mem_valid,
    output stall, busy,
    output cache_we, cache_addr, cache_data,
    output mem_rd, mem_addr
  );

  modport slave (
    output fetch_en, pc_addr, cache_hit,
    output mem_rdata, mem_valid,
    input  stall, busy,
    input  cache_we, cache_addr, cache_data,
    input  mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_refill.sv
// I-cache line refill: on a miss, reads one line word by word from memory
// and writes it into the L1 in ascending offset order.
module icache_refill #(
  parameter int ADDR_SIZE      = 14,
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic             clk,
  input  logic             reset,
  icache_refill_if.master  bus
);
  localparam int WOB = $clog2(WORDS_PER_LINE);
  localparam int BW  = ADDR_SIZE - WOB;
  localparam logic [WOB-1:0] LAST = WOB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WRITE
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        base_q, base_d;
  logic [WOB-1:0]       cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 miss;

  assign miss = bus.fetch_en & ~bus.cache_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    cnt_d          = cnt_q;
    wdata_d        = wdata_q;
    bus.stall      = 1'b0;
    bus.busy       = 1'b0;
    bus.cache_we   = 1'b0;
    bus.cache_addr = '0;
    bus.cache_data = '0;
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    unique case (state_q)
      IDLE: begin
        bus.stall = miss;
        if (miss) begin
          base_d  = bus.pc_addr[ADDR_SIZE-1:WOB];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.stall    = 1'b1;
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {base_q, cnt_q};
        if (bus.mem_valid) begin
          wdata_d = bus.mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.stall      = 1'b1;
        bus.busy       = 1'b1;
        bus.cache_we   = 1'b1;
        bus.cache_addr = {base_q, cnt_q};
        bus.cache_data = wdata_q;
        // L1 only validates the line on the final offset, so never skip ahead
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + WOB'(1);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
